// File: rtl/lm70_reader.sv
// SPI read master for the LM70 temperature sensor: frames CS/SCK, captures the
// 16-bit word from SIO and keeps an over-temperature flag with hysteresis.
module lm70_reader #(
    parameter int CLK_DIV = 4,
    parameter int GAP     = 64,
    parameter int HYST    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  temp_set,
    output logic        CS,
    output logic        SCK,
    input  logic        SIO,
    output logic [15:0] temp_word,
    output logic [7:0]  temp_deg,
    output logic        temp_neg,
    output logic        temp_valid,
    output logic        over_temp,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam int MAXC = (CLK_DIV > GAP) ? CLK_DIV : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [8:0]    HYST9    = 9'(HYST);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [15:0]    shift_q, shift_d;
    logic [15:0]    word_q, word_d;
    logic           cs_q, cs_d;
    logic           sck_q, sck_d;
    logic           valid_q, valid_d;
    logic           over_q, over_d;
    logic           busy_q, busy_d;

    // Set on a non-negative reading at or above the set-point; clear only once
    // the reading drops HYST below it (9-bit sum so a large reading cannot wrap).
    function automatic logic thermo(input logic [15:0] w, input logic [7:0] sp,
                                    input logic cur);
        logic       neg;
        logic [7:0] deg;
        logic       res;
        neg = w[15];
        deg = w[14:7];
        if (!neg && (deg >= sp)) begin
            res = 1'b1;
        end else if (neg || (({1'b0, deg} + HYST9) < {1'b0, sp})) begin
            res = 1'b0;
        end else begin
            res = cur;
        end
        return res;
    endfunction

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shift_q <= 16'h0000;
            word_q  <= 16'h0000;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            valid_q <= 1'b0;
            over_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            cs_q    <= cs_d;
            sck_q   <= sck_d;
            valid_q <= valid_d;
            over_q  <= over_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state and phase counters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = 4'd0;
                if (en) begin
                    state_d = S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SHIFT: begin
                // A low half-period ending after bit 15 closes the shift phase.
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (!sck_q && (bit_q == 4'd15)) begin
                        state_d = S_HOLD;
                        bit_d   = 4'd0;
                    end else if (!sck_q) begin
                        bit_d = bit_q + 4'd1;
                    end else begin
                        bit_d = bit_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (en) begin
                        state_d = S_SETUP;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Next values of the registered outputs, shift data and commit
    always_comb begin
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = 1'b0;
        over_d  = over_q;
        busy_d  = (state_d != S_IDLE);
        case (state_d)
            S_SETUP, S_SHIFT, S_HOLD: cs_d = 1'b0;
            default:                  cs_d = 1'b1;
        endcase
        case (state_q)
            S_SETUP: sck_d = (state_d == S_SHIFT);
            S_SHIFT: begin
                if (state_d != S_SHIFT) begin
                    sck_d = 1'b0;
                end else if (cnt_q == DIV_LAST) begin
                    sck_d = ~sck_q;
                end else begin
                    sck_d = sck_q;
                end
            end
            default: sck_d = 1'b0;
        endcase
        if (sck_d && !sck_q) begin
            shift_d = {shift_q[14:0], SIO};
        end else begin
            shift_d = shift_q;
        end
        if ((state_q == S_HOLD) && (state_d == S_GAP)) begin
            word_d  = shift_q;
            valid_d = 1'b1;
            over_d  = thermo(shift_q, temp_set, over_q);
        end else begin
            word_d  = word_q;
            valid_d = 1'b0;
            over_d  = over_q;
        end
    end

    assign CS         = cs_q;
    assign SCK        = sck_q;
    assign temp_word  = word_q;
    assign temp_deg   = word_q[14:7];
    assign temp_neg   = word_q[15];
    assign temp_valid = valid_q;
    assign over_temp  = over_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_lm70_reader.sv
// Scoreboard bench for lm70_reader with a behavioural LM70 driving SIO.
module tb_lm70_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  temp_set;
    logic        CS, SCK, SIO;
    logic [15:0] temp_word;
    logic [7:0]  temp_deg;
    logic        temp_neg, temp_valid, over_temp, busy;

    lm70_reader dut (
        .clk(clk), .rst(rst), .en(en), .temp_set(temp_set),
        .CS(CS), .SCK(SCK), .SIO(SIO),
        .temp_word(temp_word), .temp_deg(temp_deg), .temp_neg(temp_neg),
        .temp_valid(temp_valid), .over_temp(over_temp), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [7:0]  deg;
        logic        neg;
        logic        ov;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] sen_q[$];
    logic [15:0] sen_word = 16'h0000;
    logic [3:0]  sen_idx  = 4'd0;
    bit          in_frame = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc = 0, falls = 0, total_rises = 0, frame_rises = 0, low_len = 0;
    int last_fall = 0;
    bit have_prev = 1'b0;
    bit chk_period = 1'b0;
    logic cs_prev = 1'b1, sck_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // LM70 model: MSB presented at CS fall, next bit after each SCK fall.
    assign SIO = sen_word[sen_idx];
    always @(negedge CS or posedge CS or negedge SCK) begin
        if (CS !== 1'b0) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            sen_word = (sen_q.size() > 0) ? sen_q.pop_front() : 16'h0000;
            sen_idx  = 4'd15;
        end else if (sen_idx > 4'd0) begin
            sen_idx = sen_idx - 4'd1;
        end
    end

    // Monitor: frame timing and scoreboard
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            frame_rises = 0;
            low_len     = 0;
            have_prev   = 1'b0;
        end else begin
            if (SCK && !sck_prev) begin
                total_rises++;
                frame_rises++;
            end
            if (!CS) low_len++;
            if (!CS && cs_prev) begin
                falls++;
                if (chk_period && have_prev) chk("frame_period", cyc - last_fall, 200);
                last_fall = cyc;
                have_prev = 1'b1;
            end
            if (CS && !cs_prev) begin
                chk("cs_low_len", low_len, 136);
                chk("sck_rises", frame_rises, 16);
                low_len     = 0;
                frame_rises = 0;
            end
        end
        if (temp_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: word %0h with empty scoreboard", temp_word);
            end else begin
                e = sb.pop_front();
                chk("temp_word", temp_word, e.w);
                chk("temp_deg", temp_deg, e.deg);
                chk("temp_neg", temp_neg, e.neg);
                chk("over_temp", over_temp, e.ov);
                chk("cs_high_at_valid", CS, 1'b1);
            end
        end
        cs_prev  = CS;
        sck_prev = SCK;
    end

    task automatic push(input logic [15:0] w, input logic [7:0] d, input logic n, input logic o);
        exp_t e;
        e.w = w; e.deg = d; e.neg = n; e.ov = o;
        sen_q.push_back(w);
        sb.push_back(e);
    endtask

    task automatic drain(input string name, input int limit);
        for (int i = 0; i < limit && sb.size() > 0; i++) @(negedge clk);
        chk(name, sb.size(), 0);
    endtask

    initial begin
        int f;
        rst = 1'b1; en = 1'b0; temp_set = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_cs", CS, 1'b1);
        chk("rst_sck", SCK, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_word", temp_word, 16'h0000);
        chk("rst_deg", temp_deg, 8'h00);
        chk("rst_neg", temp_neg, 1'b0);
        chk("rst_valid", temp_valid, 1'b0);
        chk("rst_over", over_temp, 1'b0);
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        chk("idle_sck_rises", total_rises, 0);
        chk("idle_cs_falls", falls, 0);
        chk("idle_cs", CS, 1'b1);
        chk("idle_busy", busy, 1'b0);

        // Back-to-back frames: basic read then hysteresis walk.
        temp_set = 8'd24;
        push(16'h0C00, 8'd24, 1'b0, 1'b1);
        push(16'h0B80, 8'd23, 1'b0, 1'b1);
        push(16'h0A80, 8'd21, 1'b0, 1'b0);
        push(16'h0C00, 8'd24, 1'b0, 1'b1);
        chk_period = 1'b1;
        en = 1'b1;
        @(posedge clk); #1;
        chk("en_to_cs_low", CS, 1'b0);
        chk("busy_in_frame", busy, 1'b1);
        for (int i = 0; i < 1000 && falls < 4; i++) @(negedge clk);
        chk("stream_falls", falls, 4);
        repeat (50) @(negedge clk);
        en = 1'b0;
        chk_period = 1'b0;
        drain("stream_drain", 300);
        f = falls;
        repeat (400) @(negedge clk);
        chk("no_frame_after_en_drop", falls, f);
        chk("cs_high_after_drop", CS, 1'b1);
        chk("idle_after_drop", busy, 1'b0);

        // Negative reading clears the flag.
        temp_set = 8'd0;
        push(16'hF000, 8'hE0, 1'b1, 1'b0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        drain("neg_drain", 300);
        repeat (100) @(negedge clk);

        // Reset during the eighth SCK high phase.
        temp_set = 8'd24;
        sen_q.push_back(16'h1234);
        en = 1'b1;
        for (int i = 0; i < 200 && frame_rises < 8; i++) @(negedge clk);
        chk("abort_reached_rise8", frame_rises, 8);
        rst = 1'b1;
        en  = 1'b0;
        #1;
        chk("abort_cs", CS, 1'b1);
        chk("abort_sck", SCK, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_word", temp_word, 16'h0000);
        chk("abort_over", over_temp, 1'b0);
        repeat (5) @(negedge clk);
        chk("abort_valid", temp_valid, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        push(16'h0C00, 8'd24, 1'b0, 1'b1);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        drain("post_reset_drain", 300);
        repeat (100) @(negedge clk);
        chk("sb_empty_end", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lm70_reader.md
# lm70_reader

SPI read master for the LM70 temperature sensor model. It drives CS and SCK, shifts in the 16-bit temperature word from SIO, and extracts an integer-degree reading. It then compares that reading against a user set-point with hysteresis. It sits directly upstream of the LM70's serial port and replaces the free-running clock/CS driving used in bring-up.

## Interface
Parameters:
- CLK_DIV, default 4: clk cycles per SCK half-period; legal range ≥2.
- GAP, default 64: idle clk cycles with CS high between frames; legal range ≥1.
- HYST, default 2: over-temperature clear hysteresis, in °C.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  level; while high, frames repeat back-to-back separated by GAP.
- temp_set  in  8  set-point in whole °C, unsigned.
- CS  out  1  LM70 chip select, active low.
- SCK  out  1  serial clock, idle low.
- SIO  in  1  serial data from the LM70; this block never drives it.
- temp_word  out  16  last complete raw frame, MSB first as received.
- temp_deg  out  8  temp_word[14:7], whole °C magnitude field.
- temp_neg  out  1  temp_word[15], the sign bit.
- temp_valid  out  1  one-cycle pulse when temp_word, temp_deg and temp_neg update.
- over_temp  out  1  thermostat flag with hysteresis.
- busy  out  1  high from leaving IDLE until returning to IDLE.

## Operation
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → (SETUP if en, else IDLE).
- IDLE: CS=1, SCK=0. Moves to SETUP on the first clk edge with en=1.
- SETUP: CS=0, SCK=0 for CLK_DIV cycles.
- SHIFT:
  - SCK toggles every CLK_DIV cycles, starting high, for 16 full periods.
  - On the clk edge where SCK goes 0→1, shift_reg <= {shift_reg[14:0], SIO}, using the pre-edge SIO value.
  - A 4-bit bit counter and a divider counter track progress.
- HOLD: SCK=0, CS=0 for CLK_DIV cycles. At exit, CS→1 and the frame is committed.
- Commit (a single clk edge):
  - temp_word <= shift_reg; temp_valid=1 for that cycle.
  - Thermostat update, computed from the new word:
    - Set over_temp when temp_neg=0 and temp_deg ≥ temp_set.
    - Clear over_temp when temp_neg=1 or (temp_deg + HYST) < temp_set. Use a 9-bit add so there is no wrap.
    - Otherwise hold over_temp.
- GAP: CS=1, SCK=0 for GAP cycles.
- en deasserted mid-frame: the frame completes and commits normally, then the FSM goes to IDLE after GAP.
- temp_set is sampled only at commit. Changes between frames take effect at the next commit.

## Timing
- Reset values:
  - CS=1, SCK=0, busy=0.
  - temp_word=0, temp_deg=0, temp_neg=0, temp_valid=0, over_temp=0.
  - FSM=IDLE, all counters 0.
- Reset asserted mid-frame: the above apply immediately (asynchronous). There is no commit and no temp_valid pulse; the partial shift data is discarded.
- CS low duration per frame = CLK_DIV × 34 cycles (136 at default).
- First SCK rise occurs CLK_DIV cycles after CS falls.
- Last SCK fall occurs CLK_DIV cycles before CS rises.
- temp_valid asserts in the first cycle CS is high.
- en=1 to CS low: 1 cycle from IDLE.
- Frame period with en held high = 34×CLK_DIV + GAP cycles (200 at default).
- All outputs are registered; SCK and CS have no combinational path from any input.

## Test plan
- Reset with en=0: all outputs at reset values, CS stays 1, no SCK edges for 1000 cycles.
- Basic read:
  - Stimulus: LM70 TEMP_SET=16'h0C00 (24 °C), en=1, temp_set=24.
  - Response: exactly 16 SCK rises while CS=0; temp_word=16'h0C00, temp_deg=24, temp_neg=0, one temp_valid pulse, over_temp=1.
- Hysteresis, with temp_set=24 and over_temp already set, next frames read 23 °C, then 21 °C:
  - 23 °C (16'h0B80): over_temp stays 1.
  - 21 °C (16'h0A80): over_temp→0.
  - 24 °C again: over_temp→1.
- Negative reading:
  - Stimulus: word 16'hF000, temp_set=0.
  - Response: temp_neg=1, over_temp=0, temp_deg=8'hE0.
- Frame timing at defaults: CS low exactly 136 cycles, CS-fall to CS-fall 200 cycles. Drop en mid-frame: the frame still commits, then CS stays high.
- Reset at SCK rise #8: CS=1 and SCK=0 immediately, no temp_valid, outputs keep reset values. After release with en=1, the next frame reads correctly.
